// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner, access size codes.
// Latency: none (types only).
// Backpressure: none (types only).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/memory_port_arbiter_lane_align.sv
// Byte-lane helper: byte enables, lane-shifted store data, read right-alignment, misalignment flag.
// Latency: purely combinational.
// Backpressure: none.
module lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_fetch,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic        misalign,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_al
);

    // Size 2'b11 falls into the default arm and behaves exactly like a word.
    always_comb begin
        be       = 4'b1111;
        misalign = 1'b0;
        if (is_fetch) begin
            misalign = (addr_lo != 2'b00);
        end else begin
            case (size)
                SZ_BYTE: be = 4'b0001 << addr_lo;
                SZ_HALF: begin
                    be       = 4'b0011 << addr_lo;
                    misalign = addr_lo[0];
                end
                default: misalign = (addr_lo != 2'b00);
            endcase
        end
    end

    assign wdata_al = wdata << {addr_lo, 3'b000};
    assign rdata_al = rdata >> {rd_addr_lo, 3'b000};

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight at a time.
// Latency: gnt same cycle as request, mem_valid next cycle, rvalid/done one cycle after mem_rvalid.
// Backpressure: requests wait in IDLE until granted; ISSUE holds mem_valid stable until mem_ready.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t        state;
    owner_t            owner;
    logic [SW-1:0]     streak, streak_nxt;
    logic [TW-1:0]     timer;
    logic              we_q;
    logic [1:0]        lo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
    logic              if_rvalid_q, d_done_q, if_err_q, d_err_q;

    logic              fetch_win, data_win, misalign;
    logic [3:0]        la_be;
    logic [DATA_W-1:0] la_wdata, la_rdata;

    // Grants are combinational so a held request is never granted twice.
    assign fetch_win = reset_n && (state == IDLE) && if_req &&
                       (!d_req || (streak == SW'(MAX_DATA_STREAK)));
    assign data_win  = reset_n && (state == IDLE) && d_req && !fetch_win;

    always_comb begin
        streak_nxt = streak;
        if (fetch_win) begin
            streak_nxt = '0;
        end else if (data_win) begin
            if (!if_req)
                streak_nxt = '0;
            else if (streak != SW'(MAX_DATA_STREAK))
                streak_nxt = streak + 1'b1;
        end
    end

    lane_align u_lane_align (
        .size       (data_win ? d_size : SZ_WORD),
        .addr_lo    (data_win ? d_addr[1:0] : if_addr[1:0]),
        .is_fetch   (!data_win),
        .wdata      (d_wdata),
        .be         (la_be),
        .wdata_al   (la_wdata),
        .misalign   (misalign),
        .rd_addr_lo (lo_q),
        .rdata      (mem_rdata),
        .rdata_al   (la_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= OWN_FETCH;
            streak      <= '0;
            timer       <= '0;
            we_q        <= 1'b0;
            lo_q        <= 2'b00;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_win || data_win) begin
                        streak <= streak_nxt;
                        // Misaligned grants are answered by the same-cycle err pulse only.
                        if (!misalign) begin
                            state   <= ISSUE;
                            owner   <= fetch_win ? OWN_FETCH : OWN_DATA;
                            we_q    <= data_win && d_we;
                            addr_q  <= data_win ? {d_addr[ADDR_W-1:2], 2'b00}
                                                : {if_addr[ADDR_W-1:2], 2'b00};
                            lo_q    <= data_win ? d_addr[1:0] : 2'b00;
                            be_q    <= la_be;
                            wdata_q <= la_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        if (we_q) begin
                            d_done_q <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            timer <= '0;
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_FETCH) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= mem_rdata;
                        end else begin
                            d_done_q  <= 1'b1;
                            d_rdata_q <= la_rdata;
                        end
                        state <= IDLE;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        if (owner == OWN_FETCH) if_err_q <= 1'b1;
                        else                    d_err_q  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign if_gnt    = fetch_win;
    assign d_gnt     = data_win;
    assign if_err    = if_err_q | (fetch_win & misalign);
    assign d_err     = d_err_q  | (data_win & misalign);
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mem_valid = (state == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (FETCH state) and the data requester (load/store EXECUTE) of the multicycle core.
- Serialises requests with one transaction outstanding at a time.
- Generates byte enables and lane-aligned write data for SB/SH/SW, and right-aligns read data for the loads.
- Detects misaligned accesses and memory timeouts.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, four byte lanes.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for read response.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address (pc)
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  instruction word valid (1-cycle pulse)
- if_rdata  out  32  instruction word
- if_err  out  1  misaligned fetch or timeout (1-cycle pulse)
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word
- d_addr  in  ADDR_W  effective address (alu_result)
- d_wdata  in  32  store data (rs2), low-aligned
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_done  out  1  load data valid or store written (1-cycle pulse)
- d_rdata  out  32  read word shifted right by 8*addr[1:0]; sign/zero extension stays in control_unit
- d_err  out  1  misaligned access or timeout (1-cycle pulse)
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_we  out  1  write
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_rvalid  in  1  read response valid
- mem_rdata  in  32  read response

Behaviour:
- Reset: async on reset_n low.
  - State IDLE, streak = 0, timer = 0.
  - All outputs 0, including mem_valid; an in-flight transaction is abandoned, with no done or err pulse.
  - A mem_rvalid arriving after reset release while in IDLE is ignored.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE arbitration:
  - Data wins by default.
  - Fetch wins if only if_req is high.
  - Fetch also wins if both are high and streak == MAX_DATA_STREAK.
  - Streak increments on each data grant made while if_req is high, saturating at MAX_DATA_STREAK. It clears on any fetch grant and on any data grant made while if_req is low.
- Grant cycle: the winner's gnt pulses. Owner, we, word address, be and aligned wdata are registered. Next state is ISSUE.
- Misalignment, checked at grant:
  - half with addr[0] = 1, word with addr[1:0] != 0, or fetch with addr[1:0] != 0.
  - gnt and err pulse together in the same cycle; no memory access is made; state stays IDLE; streak is updated as for a normal grant.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
  - mem_wdata = d_wdata << (8*addr[1:0]).
  - d_size = 11 is treated as word.
- ISSUE:
  - mem_valid = 1 with the registered fields, held stable until mem_ready.
  - On mem_ready with a store: d_done pulses next cycle; go to IDLE.
  - On mem_ready with a read: go to WAIT_RESP with timer cleared.
- WAIT_RESP:
  - On mem_rvalid, the owner's rvalid/done pulses next cycle with the registered data. Fetch gets the raw word; data gets the word right-shifted by 8*addr[1:0]. Go to IDLE.
  - The timer increments each cycle. When timer == TIMEOUT_CYCLES-1 without rvalid, the owner's err pulses; go to IDLE.
- Latency: fetch with zero-wait memory (mem_ready and mem_rvalid the cycle after they are sampled) takes gnt at cycle 0, mem_valid at cycle 1, rvalid at cycle 3.
- Back-to-back: a new grant is possible in the IDLE cycle that follows a done pulse.
- Simultaneous mem_rvalid and timeout expiry: rvalid wins.
- Owner rdata outputs hold their last value between pulses.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT_RESP).
  - owner_t enum (OWN_FETCH, OWN_DATA).
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
- Sub-module lane_align: combinational be/wdata generation, read realignment and misalignment flag from size and addr[1:0].

Test Plan:
- Fetch only, if_addr = 0x0000_0010, memory returns 0x0041_0113 → mem_addr = 0x10, mem_be = 4'b1111, if_rvalid pulse with if_rdata = 0x0041_0113.
- SB, d_addr = 0x103, d_wdata = 0x0000_00AB → mem_be = 4'b1000, mem_wdata = 0xAB00_0000, mem_addr = 0x100, d_done pulse.
- LH, d_addr = 0x102, mem_rdata = 0xBEEF_1234 → d_rdata = 0x0000_BEEF, d_done pulse.
- SW, d_addr = 0x102 → d_gnt and d_err pulse in the same cycle, mem_valid never asserts.
- if_req and d_req held high continuously, MAX_DATA_STREAK = 4 → grant order D, D, D, D, F, D….
- Read with mem_rvalid withheld 64 cycles → d_err pulse, return to IDLE; reset_n low during ISSUE → mem_valid drops immediately, no d_done.
